// File: rtl/imem_loader_if.sv
// Boot-loader bus: UART byte stream in, instruction-RAM write port and
// session status out. The loader takes the slave side.
interface imem_loader_if #(
  parameter int LEN_WIDTH = 16
);
  logic                 start;
  logic                 rx_valid;
  logic [7:0]           rx_data;
  logic                 mem_we;
  logic [31:0]          mem_addr;
  logic [31:0]          mem_wdata;
  logic                 cpu_hold;
  logic                 done;
  logic                 err;
  logic [LEN_WIDTH-1:0] word_count;

  modport master (
    output start, rx_valid, rx_data,
    input  mem_we, mem_addr, mem_wdata, cpu_hold, done, err, word_count
  );

  modport slave (
    input  start, rx_valid, rx_data,
    output mem_we, mem_addr, mem_wdata, cpu_hold, done, err, word_count
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory boot loader: 16-bit word-count header, then big-endian
// 32-bit words written from byte address 0. Optional trailing XOR checksum
// byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE
  } state_t;

  state_t               r_state;
  logic [7:0]           r_len_hi;
  logic [LEN_WIDTH-1:0] r_len;
  logic [1:0]           r_byte_idx;
  logic [23:0]          r_word;
  logic                 r_mem_we;
  logic [31:0]          r_mem_addr;
  logic [31:0]          r_mem_wdata;
  logic                 r_cpu_hold;
  logic                 r_done;
  logic                 r_err;
  logic [LEN_WIDTH-1:0] r_word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]           r_xor;
`endif

  logic [LEN_WIDTH-1:0] w_len;
  logic                 w_in_range;
  logic                 w_last_word;

  assign w_len       = LEN_WIDTH'({r_len_hi, bus.rx_data});
  // Words past the end of the RAM are swallowed rather than aliased.
  assign w_in_range  = (r_word_count >> ADDR_WIDTH) == '0;
  assign w_last_word = r_word_count == (r_len - LEN_WIDTH'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_len_hi     <= '0;
      r_len        <= '0;
      r_byte_idx   <= '0;
      r_word       <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_cpu_hold   <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_xor        <= '0;
`endif
    end else begin
      // NOTE: default-low first so mem_we is a one-cycle pulse; later
      // non-blocking writes in this block override it.
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_word_count <= '0;
            r_byte_idx   <= '0;
            r_cpu_hold   <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor        <= '0;
`endif
            r_state      <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (bus.rx_valid) begin
            r_len_hi <= bus.rx_data;
            r_state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (bus.rx_valid) begin
            r_len <= w_len;
            if (w_len != '0) begin
              r_state <= S_DATA;
            end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              r_state <= S_CHK;
`else
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
`endif
            end
          end
        end
        S_DATA: begin
          if (bus.rx_valid) begin
            r_word     <= {r_word[15:0], bus.rx_data};
            r_byte_idx <= r_byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor      <= r_xor ^ bus.rx_data;
`endif
            if (r_byte_idx == 2'd3) begin
              r_word_count <= r_word_count + LEN_WIDTH'(1);
              if (w_in_range) begin
                r_mem_we    <= 1'b1;
                r_mem_wdata <= {r_word, bus.rx_data};
                r_mem_addr  <= {{(30-ADDR_WIDTH){1'b0}},
                                r_word_count[ADDR_WIDTH-1:0], 2'b00};
              end else begin
                r_err <= 1'b1;
              end
              if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_state <= S_CHK;
`else
                r_state    <= S_DONE;
                r_done     <= 1'b1;
                r_cpu_hold <= 1'b0;
`endif
              end
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (bus.rx_valid) begin
            if (bus.rx_data != r_xor) r_err <= 1'b1;
            r_state    <= S_DONE;
            r_done     <= 1'b1;
            r_cpu_hold <= 1'b0;
          end
        end
`endif
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.cpu_hold   = r_cpu_hold;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.word_count = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a default-size loader plus a 4-word
// loader for overflow, with write scoreboards checked from a negedge monitor.
module tb_imem_loader;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tb_start = 1'b0;
  logic       tb_sel = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;

  imem_loader_if #(.LEN_WIDTH(16)) bus0 ();
  imem_loader_if #(.LEN_WIDTH(16)) bus1 ();

  assign bus0.start    = tb_start & ~tb_sel;
  assign bus1.start    = tb_start & tb_sel;
  assign bus0.rx_valid = rx_valid;
  assign bus1.rx_valid = rx_valid;
  assign bus0.rx_data  = rx_data;
  assign bus1.rx_data  = rx_data;

  imem_loader #(.ADDR_WIDTH(8), .LEN_WIDTH(16)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  imem_loader #(.ADDR_WIDTH(2), .LEN_WIDTH(16)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  wr_t         q0[$];
  wr_t         q1[$];
  logic [31:0] payload[$];
  int          rem;
  bit          hold_ok;
  logic        prev0 = 1'b0;
  logic        prev1 = 1'b0;

  logic        s_hold, s_done, s_err;
  logic [15:0] s_wc;
  assign s_hold = tb_sel ? bus1.cpu_hold   : bus0.cpu_hold;
  assign s_done = tb_sel ? bus1.done       : bus0.done;
  assign s_err  = tb_sel ? bus1.err        : bus0.err;
  assign s_wc   = tb_sel ? bus1.word_count : bus0.word_count;

  // Write monitors: every mem_we pulse must match the next expected write.
  always @(negedge clk) begin : mon0
    wr_t e;
    if (bus0.mem_we === 1'b1) begin
      checks++;
      if (prev0 === 1'b1) begin
        errors++;
        $display("FAIL dut0_we_width: mem_we high two cycles, addr=%h", bus0.mem_addr);
      end else if (q0.size() == 0) begin
        errors++;
        $display("FAIL dut0_write: unexpected write addr=%h data=%h", bus0.mem_addr, bus0.mem_wdata);
      end else begin
        e = q0.pop_front();
        if ({bus0.mem_addr, bus0.mem_wdata} !== e) begin
          errors++;
          $display("FAIL dut0_write: got addr=%h data=%h, want addr=%h data=%h",
                   bus0.mem_addr, bus0.mem_wdata, e.addr, e.data);
        end
      end
    end
    prev0 = bus0.mem_we;
  end

  always @(negedge clk) begin : mon1
    wr_t e;
    if (bus1.mem_we === 1'b1) begin
      checks++;
      if (prev1 === 1'b1) begin
        errors++;
        $display("FAIL dut1_we_width: mem_we high two cycles, addr=%h", bus1.mem_addr);
      end else if (q1.size() == 0) begin
        errors++;
        $display("FAIL dut1_write: unexpected write addr=%h data=%h", bus1.mem_addr, bus1.mem_wdata);
      end else begin
        e = q1.pop_front();
        if ({bus1.mem_addr, bus1.mem_wdata} !== e) begin
          errors++;
          $display("FAIL dut1_write: got addr=%h data=%h, want addr=%h data=%h",
                   bus1.mem_addr, bus1.mem_wdata, e.addr, e.data);
        end
      end
    end
    prev1 = bus1.mem_we;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
    repeat (gap) step();
  endtask

  task automatic send_b(input logic [7:0] b, input int gap);
    hold_ok = hold_ok & (s_hold === 1'b1);
    rem--;
    drive_byte(b, (rem == 0) ? 0 : gap);
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({bus0.mem_we, bus0.mem_addr, bus0.mem_wdata, bus0.cpu_hold, bus0.done,
         bus0.err, bus0.word_count} !== '0) begin
      errors++;
      $display("FAIL %s_dut0: we=%b addr=%h wdata=%h hold=%b done=%b err=%b wc=%0d, want all 0",
               tag, bus0.mem_we, bus0.mem_addr, bus0.mem_wdata, bus0.cpu_hold,
               bus0.done, bus0.err, bus0.word_count);
    end
    checks++;
    if ({bus1.mem_we, bus1.mem_addr, bus1.mem_wdata, bus1.cpu_hold, bus1.done,
         bus1.err, bus1.word_count} !== '0) begin
      errors++;
      $display("FAIL %s_dut1: we=%b addr=%h hold=%b done=%b err=%b wc=%0d, want all 0",
               tag, bus1.mem_we, bus1.mem_addr, bus1.cpu_hold, bus1.done,
               bus1.err, bus1.word_count);
    end
  endtask

  // Full session: start, header, payload words, optional checksum byte.
  task automatic run_session(input string tag, input bit sel, input int n, input int gap,
                             input logic [7:0] chk_flip, input int ram_words,
                             input logic exp_err);
    logic [15:0] nn;
    logic [31:0] w;
    logic [7:0]  x;
    logic [7:0]  b;
    wr_t         e;
    nn = 16'(n);
    x  = 8'h00;
    tb_sel   = sel;
    tb_start = 1'b1;
    step();
    tb_start = 1'b0;
    checks++;
    if (s_hold !== 1'b1) begin
      errors++;
      $display("FAIL %s_hold_start: cpu_hold=%b, want 1", tag, s_hold);
    end
    hold_ok = 1'b1;
    rem = 2 + 4 * n;
`ifdef IMEM_LOADER_CHECKSUM_EN
    rem++;
`endif
    send_b(nn[15:8], gap);
    send_b(nn[7:0], gap);
    for (int i = 0; i < n; i++) begin
      w = payload[i];
      for (int j = 0; j < 4; j++) begin
        b = w[31 - 8*j -: 8];
        x = x ^ b;
        if (j == 3 && i < ram_words) begin
          e.addr = 32'(i) << 2;
          e.data = w;
          if (sel) q1.push_back(e);
          else     q0.push_back(e);
        end
        send_b(b, gap);
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_b(x ^ chk_flip, gap);
`else
    if (chk_flip != 8'h00) x = x ^ chk_flip;
`endif
    checks++;
    if (s_done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done: done=%b one cycle after last byte, want 1", tag, s_done);
    end
    checks++;
    if (!hold_ok) begin
      errors++;
      $display("FAIL %s_hold_during: cpu_hold dropped during load, want 1", tag);
    end
    checks++;
    if (s_hold !== 1'b0) begin
      errors++;
      $display("FAIL %s_hold_end: cpu_hold=%b, want 0", tag, s_hold);
    end
    checks++;
    if (s_err !== exp_err) begin
      errors++;
      $display("FAIL %s_err: err=%b, want %b", tag, s_err, exp_err);
    end
    checks++;
    if (s_wc !== nn) begin
      errors++;
      $display("FAIL %s_word_count: word_count=%0d, want %0d", tag, s_wc, nn);
    end
    step();
    step();
    checks++;
    if (q0.size() + q1.size() != 0) begin
      errors++;
      $display("FAIL %s_writes: %0d expected writes missing, want 0", tag, q0.size() + q1.size());
    end
    q0.delete();
    q1.delete();
    checks++;
    if (s_done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_hold: done=%b after return to idle, want 1", tag, s_done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) step();
    check_idle_outputs("reset");
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    payload = '{32'h241A0001, 32'h8C080000};
    run_session("basic", 1'b0, 2, 1, 8'h00, 256, 1'b0);
  endtask

  task automatic test_back_to_back();
    payload = '{};
    for (int i = 0; i < 3; i++) payload.push_back($urandom());
    run_session("b2b", 1'b0, 3, 0, 8'h00, 256, 1'b0);
  endtask

  task automatic test_zero_len();
    payload = '{};
    run_session("zero", 1'b0, 0, 1, 8'h00, 256, 1'b0);
  endtask

  task automatic test_overflow();
    payload = '{};
    for (int i = 0; i < 5; i++) payload.push_back(32'hA5000000 | 32'(i * 17) | $urandom_range(0, 255) << 8);
    run_session("ovf", 1'b1, 5, 1, 8'h00, 4, 1'b1);
  endtask

  task automatic test_reset_mid();
    wr_t e;
    payload = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};
    tb_sel   = 1'b0;
    tb_start = 1'b1;
    step();
    tb_start = 1'b0;
    rem = 1000;
    hold_ok = 1'b1;
    send_b(8'h00, 1);
    send_b(8'h04, 1);
    e.addr = 32'h0;
    e.data = payload[0];
    q0.push_back(e);
    for (int k = 0; k < 6; k++) send_b(payload[k / 4][31 - 8*(k % 4) -: 8], 1);
    step();
    checks++;
    if (q0.size() != 0 || bus0.cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: pending=%0d hold=%b, want 0 and 1", q0.size(), bus0.cpu_hold);
    end
    #2 reset = 1'b1;
    #1;
    check_idle_outputs("rstmid_async");
    step();
    reset = 1'b0;
    step();
    payload = '{32'hCAFEF00D, 32'h0BADBEEF, 32'h12345678};
    run_session("rstmid_reload", 1'b0, 3, 1, 8'h00, 256, 1'b0);
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    payload = '{32'h01020304};
    run_session("chk_good", 1'b0, 1, 1, 8'h00, 256, 1'b0);
    payload = '{32'h01020304};
    run_session("chk_bad", 1'b0, 1, 1, 8'h01, 256, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_zero_len();
    test_overflow();
    test_reset_mid();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface: a boot loader that accepts a byte stream from the UART receiver, assembles 32-bit big-endian instruction words, and writes them sequentially into the writable instruction RAM starting at byte address 0.
- Holds the CPU pipeline stalled while loading.
- Sits between the UART RX block and the instruction RAM write port; the CPU fetch path reads the RAM as usual once loading completes.

Parameters:
- ADDR_WIDTH, 8, word-address width of instruction RAM (256 words; byte address bits [ADDR_WIDTH+1:2])
- LEN_WIDTH, 16, width of the word-count header

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  single-cycle pulse: begin a load session
- rx_valid  input  1  one-cycle strobe: rx_data holds a received byte
- rx_data  input  8  received byte
- mem_we  output  1  instruction RAM write enable, one-cycle pulse per word
- mem_addr  output  32  byte address of write; bits [1:0] always 0
- mem_wdata  output  32  instruction word to write
- cpu_hold  output  1  stall/hold CPU while 1
- done  output  1  level: last session completed
- err  output  1  level: last session overflowed (or checksum failed)
- word_count  output  LEN_WIDTH  words written in current/last session

Behaviour:
- Reset (async, immediate): state=IDLE; mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, done=0, err=0, word_count=0; partial byte assembly discarded.
- States: IDLE, LEN_HI, LEN_LO, DATA, (CHK if CHECKSUM_EN), DONE.
- IDLE: rx bytes ignored. On start: done=0, err=0, word_count=0, byte index=0, cpu_hold=1 next cycle; go to LEN_HI.
- LEN_HI: on rx_valid, latch N[15:8]; go to LEN_LO.
- LEN_LO: on rx_valid, latch N[7:0]. If N==0, go to DONE (no writes). Otherwise go to DATA.
- DATA: bytes are big-endian; first byte lands in word[31:24]. The 2-bit byte index wraps 3→0.
- On the 4th byte of word k:
  - Register mem_wdata=word, mem_addr=k<<2, mem_we=1 for exactly the following cycle.
  - word_count increments in that same cycle.
- A byte arriving in the cycle mem_we is high is accepted normally; no byte is ever dropped, even back-to-back rx_valid.
- After word N-1 is accepted, go to DONE (or CHK).
- Overflow: words with index >= 2**ADDR_WIDTH are consumed but not written (mem_we stays 0). err=1 latched; word_count still counts them.
- DONE: cpu_hold=0, done=1 (held until next start or reset); return to IDLE the cycle after entering DONE.
- start while not IDLE is ignored.
- Reset mid-session aborts immediately. Words already written stay in RAM; cpu_hold drops to 0.
- mem_addr upper bits above ADDR_WIDTH+1 are always 0.
- Latency: mem_we asserts 1 cycle after the rx_valid carrying the 4th byte. done asserts 1 cycle after the final byte (or after the checksum byte).

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of all data bytes (header excluded) is kept, reset at start.
  - After the last data byte, state CHK accepts one extra byte.
  - If the extra byte differs from the running XOR, err=1.
  - Then go to DONE.
  - With N==0, CHK still expects one byte, and it must equal 0x00.
- Undefined: no CHK state, no checksum logic; err reflects overflow only.

Test Plan:
- Reset then start, bytes 00 02 24 1A 00 01 8C 08 00 00 -> mem_we pulses twice: addr 0x0 data 0x241A0001, then addr 0x4 data 0x8C080000; word_count=2, done=1, err=0, cpu_hold=1 from the cycle after start until done.
- Back-to-back rx_valid every cycle for N=3 -> three writes at 0x0/0x4/0x8, no byte lost, each mem_we exactly 1 cycle wide.
- Header 00 00 -> no mem_we, done=1 within 1 cycle of the second header byte (checksum build: after a trailing 00).
- ADDR_WIDTH=2, N=5 -> writes at 0x0..0xC only, fifth word not written, err=1, word_count=5.
- Assert reset after 6 data bytes of N=4 -> all outputs return to reset values asynchronously. A new start plus a full stream then loads correctly from address 0.
- (CHECKSUM_EN) N=1, word 0x01020304, check byte 0x04 -> err=0; repeat with check byte 0x05 -> err=1, word still written.
